// File: rtl/pll_seq_pkg.sv
// Shared definitions for the PLL reset sequencer: state encoding, default
// parameter values and the counter sizing helper.
package pll_seq_pkg;

  typedef enum logic [2:0] {
    StHold     = 3'd0,
    StWaitLock = 3'd1,
    StStable   = 3'd2,
    StRun      = 3'd3,
    StFail     = 3'd4
  } seq_state_e;

  localparam int unsigned DefRstHoldCycles = 16;
  localparam int unsigned DefLockTimeout   = 125000;  // 1 ms at 125 MHz
  localparam int unsigned DefLockStable    = 1024;
  localparam int unsigned DefMaxRetries    = 7;
  localparam int unsigned DefCntW          = 20;

  // Bits needed for a counter that runs from 0 up to max_val-1.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 2) ? 1 : $clog2(max_val);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Single-bit two-flop synchronizer, cleared by the asynchronous reset.
module sync_2ff (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta_q;
  logic r_sync_q;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_meta_q <= 1'b0;
      r_sync_q <= 1'b0;
    end else begin
      r_meta_q <= d_i;
      r_sync_q <= r_meta_q;
    end
  end

  assign q_o = r_sync_q;

endmodule

// File: rtl/pll_reset_sequencer.sv
// PLL reset sequencer: pulses the PLL reset, waits for a stable lock, then
// releases the system reset. Retries on lock timeout and re-sequences on loss
// of lock. Runs entirely on the reference clock.
module pll_reset_sequencer
  import pll_seq_pkg::*;
#(
  parameter int unsigned RST_HOLD_CYCLES = DefRstHoldCycles,
  parameter int unsigned LOCK_TIMEOUT    = DefLockTimeout,
  parameter int unsigned LOCK_STABLE     = DefLockStable,
  parameter int unsigned MAX_RETRIES     = DefMaxRetries,
  parameter int unsigned CNT_W           = DefCntW
) (
  input  logic       clk_i,
  input  logic       rst_n_i,
  input  logic       pll_locked_i,
  input  logic       restart_i,
  output logic       pll_rst_o,
  output logic       sys_rst_n_o,
  output logic       ready_o,
  output logic       fail_o,
  output logic [3:0] retry_cnt_o,
  output logic [7:0] lol_cnt_o
);

  localparam logic [CNT_W-1:0] HoldLast    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] StableLast  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [3:0]       RetryMax    = 4'(MAX_RETRIES);

  logic             w_locked_s;
  seq_state_e       r_state_q, w_state_d;
  logic [CNT_W-1:0] r_cnt_q, w_cnt_d;
  logic [3:0]       r_retry_q, w_retry_d;
  logic [7:0]       r_lol_q, w_lol_d;
  logic             r_pll_rst_q, r_sys_rst_n_q, r_ready_q, r_fail_q;

  sync_2ff u_locked_sync (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .d_i     (pll_locked_i),
    .q_o     (w_locked_s)
  );

  // Next-state, shared counter and status counter updates.
  always_comb begin
    w_state_d = r_state_q;
    w_cnt_d   = r_cnt_q;
    w_retry_d = r_retry_q;
    w_lol_d   = r_lol_q;
    unique case (r_state_q)
      StHold: begin
        if (r_cnt_q == HoldLast) begin
          w_state_d = StWaitLock;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt_q + 1'b1;
        end
      end
      StWaitLock: begin
        // A lock seen on the final timeout cycle still counts as a lock.
        if (w_locked_s) begin
          w_state_d = StStable;
          w_cnt_d   = '0;
        end else if (r_cnt_q == TimeoutLast) begin
          w_cnt_d = '0;
          if (r_retry_q < RetryMax) begin
            w_retry_d = r_retry_q + 4'd1;
            w_state_d = StHold;
          end else begin
            w_state_d = StFail;
          end
        end else begin
          w_cnt_d = r_cnt_q + 1'b1;
        end
      end
      StStable: begin
        // A dropout here is treated as a glitch, not a loss-of-lock event.
        if (!w_locked_s) begin
          w_state_d = StWaitLock;
          w_cnt_d   = '0;
        end else if (r_cnt_q == StableLast) begin
          w_state_d = StRun;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!w_locked_s) begin
          if (r_lol_q != 8'hFF) w_lol_d = r_lol_q + 8'd1;
          w_retry_d = '0;
          w_state_d = StHold;
          w_cnt_d   = '0;
        end
      end
      StFail: begin
        w_state_d = StFail;
      end
      default: begin
        w_state_d = StHold;
        w_cnt_d   = '0;
      end
    endcase
    // Restart overrides the destination but keeps any loss-of-lock count.
    if (restart_i) begin
      w_state_d = StHold;
      w_cnt_d   = '0;
      w_retry_d = '0;
    end
  end

  // State, counter and status registers.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state_q <= StHold;
      r_cnt_q   <= '0;
      r_retry_q <= '0;
      r_lol_q   <= '0;
    end else begin
      r_state_q <= w_state_d;
      r_cnt_q   <= w_cnt_d;
      r_retry_q <= w_retry_d;
      r_lol_q   <= w_lol_d;
    end
  end

  // Outputs decoded from the next state so they switch with the state.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_pll_rst_q   <= 1'b1;
      r_sys_rst_n_q <= 1'b0;
      r_ready_q     <= 1'b0;
      r_fail_q      <= 1'b0;
    end else begin
      r_pll_rst_q   <= (w_state_d == StHold);
      r_sys_rst_n_q <= (w_state_d == StRun);
      r_ready_q     <= (w_state_d == StRun);
      r_fail_q      <= (w_state_d == StFail);
    end
  end

  assign pll_rst_o   = r_pll_rst_q;
  assign sys_rst_n_o = r_sys_rst_n_q;
  assign ready_o     = r_ready_q;
  assign fail_o      = r_fail_q;
  assign retry_cnt_o = r_retry_q;
  assign lol_cnt_o   = r_lol_q;

endmodule
